// File: rtl/fetch_stage.sv
// Beta pipeline instruction-fetch stage: owns the PC, drives the instruction-memory
// address, and loads the decode-stage register with fetched, bubble or trap words.
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0008,
  parameter logic [31:0] NOP_INSTR = 32'h83FF_F800,
  parameter logic [31:0] IRQ_INSTR = 32'h7BDF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ir_decode,
  output logic [31:0] pc_decode,
  output logic        valid_decode,
  output logic [31:0] pc
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic            valid_q, valid_d;
  logic            irq_pending_q, irq_pending_d;
  logic [XLEN-1:0] pc_inc;
  logic            take_irq;

  // Increment never touches the supervisor bit; the low 31 bits wrap.
  assign pc_inc   = {pc_q[XLEN-1], 31'(pc_q[XLEN-2:0] + 31'd4)};
  assign take_irq = irq_pending_q & ~pc_q[XLEN-1] & ~stall & ~branch_taken;

  always_comb begin
    pc_d          = pc_q;
    ir_d          = ir_q;
    pcd_d         = pcd_q;
    valid_d       = valid_q;
    irq_pending_d = irq_pending_q | irq;
    if (stall) begin
      pc_d = pc_q;
    end else if (branch_taken) begin
      // A user-mode branch can never raise the supervisor bit.
      pc_d    = {branch_target[XLEN-1] & pcd_q[XLEN-1], branch_target[XLEN-2:2], 2'b00};
      ir_d    = NOP_INSTR;
      pcd_d   = '0;
      valid_d = 1'b0;
    end else if (take_irq) begin
      // The word at pc is dropped; the handler returns to XP-4 to re-fetch it.
      ir_d          = IRQ_INSTR;
      pcd_d         = pc_inc;
      valid_d       = 1'b1;
      pc_d          = IRQ_VEC;
      irq_pending_d = 1'b0;
    end else begin
      ir_d    = imem_data;
      pcd_d   = pc_inc;
      valid_d = 1'b1;
      pc_d    = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VEC;
      ir_q          <= NOP_INSTR;
      pcd_q         <= '0;
      valid_q       <= 1'b0;
      irq_pending_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      pcd_q         <= pcd_d;
      valid_q       <= valid_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign ir_decode    = ir_q;
  assign pc_decode    = pcd_q;
  assign valid_decode = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle model of the fetch rules checked every
// cycle, plus literal expectations at the interesting points of the sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h83FF_F800;
  localparam logic [31:0] TRAP = 32'h7BDF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        irq = 1'b0;
  logic [31:0] imem_addr, imem_data, ir_decode, pc_decode, pc;
  logic        valid_decode;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .irq(irq), .imem_addr(imem_addr),
    .imem_data(imem_data), .ir_decode(ir_decode), .pc_decode(pc_decode),
    .valid_decode(valid_decode), .pc(pc)
  );

  // Instruction memory: every word encodes its own address.
  assign imem_data = 32'h1000_0000 + imem_addr;

  always #5 clk = ~clk;

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_ir, m_pcd, m_nxt;
  logic        m_valid, m_pend;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    m_nxt = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    if (rst) begin
      m_pc = 32'h8000_0000; m_ir = NOP; m_pcd = 0; m_valid = 0; m_pend = 0;
      m_init = 1'b1;
    end else if (stall) begin
      m_pend = m_pend | irq;
    end else if (branch_taken) begin
      m_pc = (branch_target & 32'hFFFF_FFFC) &
             (m_pcd[31] ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
      m_ir = NOP; m_pcd = 0; m_valid = 0;
      m_pend = m_pend | irq;
    end else if (m_pend && !m_pc[31]) begin
      m_ir = TRAP; m_pcd = m_nxt; m_valid = 1;
      m_pc = 32'h8000_0008; m_pend = 0;
    end else begin
      m_ir = 32'h1000_0000 + m_pc; m_pcd = m_nxt; m_valid = 1; m_pc = m_nxt;
      m_pend = m_pend | irq;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      n_cmp++;
      if (imem_addr !== m_pc || pc !== m_pc || ir_decode !== m_ir ||
          pc_decode !== m_pcd || valid_decode !== m_valid) begin
        n_bad++;
        $display("FAIL model t=%0t: addr=%h pc=%h ir=%h pcd=%h v=%b required addr/pc=%h ir=%h pcd=%h v=%b",
                 $time, imem_addr, pc, ir_decode, pc_decode, valid_decode,
                 m_pc, m_ir, m_pcd, m_valid);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [31:0] t, input logic i);
    rst = r; stall = s; branch_taken = b; branch_target = t; irq = i;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset_pc", pc, 32'h8000_0000);
    chk("reset_ir", ir_decode, NOP);
    chk("reset_pcd", pc_decode, 32'h0);
    chk("reset_valid", 32'(valid_decode), 32'h0);

    run(1);
    chk("run1_addr", imem_addr, 32'h8000_0004);
    chk("run1_ir", ir_decode, 32'h9000_0000);
    chk("run1_pcd", pc_decode, 32'h8000_0004);
    chk("run1_valid", 32'(valid_decode), 32'h1);
    run(1);
    chk("run2_addr", imem_addr, 32'h8000_0008);
    chk("run2_ir", ir_decode, 32'h9000_0004);
    run(2);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 0);
      chk("stall_addr", imem_addr, 32'h8000_0010);
      chk("stall_ir", ir_decode, 32'h9000_000C);
    end
    run(1);
    chk("post_stall_ir", ir_decode, 32'h9000_0010);
    chk("post_stall_pcd", pc_decode, 32'h8000_0014);

    run(4);
    chk("pre_br_pcd", pc_decode, 32'h8000_0024);
    cyc(0, 0, 1, 32'h0000_0200, 0);
    chk("br_pc", pc, 32'h0000_0200);
    chk("br_ir", ir_decode, NOP);
    chk("br_valid", 32'(valid_decode), 32'h0);
    run(1);
    chk("br_target_ir", ir_decode, 32'h1000_0200);
    chk("br_target_pcd", pc_decode, 32'h0000_0204);
    run(1);
    cyc(0, 0, 1, 32'h8000_0040, 0);
    chk("user_br_pc", pc, 32'h0000_0040);
    cyc(0, 1, 1, 32'h0000_0500, 0);
    chk("stall_br_pc", pc, 32'h0000_0040);

    cyc(0, 0, 1, 32'h0000_0100, 0);
    cyc(0, 1, 0, 0, 1);
    chk("irq_stall_pc", pc, 32'h0000_0100);
    run(1);
    chk("trap_ir", ir_decode, TRAP);
    chk("trap_pcd", pc_decode, 32'h0000_0104);
    chk("trap_pc", pc, 32'h8000_0008);
    chk("trap_valid", 32'(valid_decode), 32'h1);

    run(6);
    chk("sup_pc", pc, 32'h8000_0020);
    cyc(0, 0, 0, 0, 1);
    chk("masked_pc", pc, 32'h8000_0024);
    chk("masked_ir", ir_decode, 32'h9000_0020);
    run(2);
    chk("masked_ir2", ir_decode, 32'h9000_0028);
    cyc(0, 0, 1, 32'h0000_0300, 0);
    chk("br300_pc", pc, 32'h0000_0300);
    run(1);
    chk("trap2_ir", ir_decode, TRAP);
    chk("trap2_pcd", pc_decode, 32'h0000_0304);
    chk("trap2_pc", pc, 32'h8000_0008);

    run(1);
    cyc(0, 0, 1, 32'h0000_0400, 0);
    run(1);
    chk("no_retrap_ir", ir_decode, 32'h1000_0400);

    cyc(0, 0, 1, 32'h7FFF_FFFF, 0);
    chk("wrap_br_pc", pc, 32'h7FFF_FFFC);
    run(1);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_pcd", pc_decode, 32'h0000_0000);
    chk("wrap_ir", ir_decode, 32'h8FFF_FFFC);

    cyc(0, 1, 0, 0, 1);
    cyc(1, 1, 1, 32'h0000_0600, 0);
    chk("rst_stall_pc", pc, 32'h8000_0000);
    chk("rst_stall_valid", 32'(valid_decode), 32'h0);
    cyc(0, 0, 1, 32'h0000_0010, 0);
    run(1);
    chk("rst_clears_pend", ir_decode, 32'h1000_0010);
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
